exec_seq_ctrl: RTL and testbench

//  Multi-cycle execute-stage sequencer for the Y86-64 SEQ core. Accepts one decoded

---
 rtl/exec_seq_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_exec_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle Y86-64 execute-stage sequencer: operand select, sliced ALU, CC register, Cnd.
// Optional macro EXEC_LOGIC_FAST_EN: AND/XOR and stack +/-8 finish in one 64-bit CALC cycle.
module exec_seq_ctrl #(
    parameter int unsigned SLICE_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc,
    output logic        err
);
    localparam int unsigned NSL   = 64 / SLICE_W;
    localparam int unsigned CNT_W = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR} alu_op_e;

    state_e             state_q, state_d;
    alu_op_e            op_q, op_d, op_sel;
    logic [63:0]        a_q, a_d, b_q, b_d, e_q, e_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d, as_q, as_d, bs_q, bs_d, upd_q, upd_d;
    logic               cnd_q, cnd_d, err_q, err_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [2:0]         cc_q, cc_d;
    logic [63:0]        alu_a, alu_b, e_fin;
    logic               needs_calc, last, of_c, co;
    logic [SLICE_W-1:0] a_sl, b_sl, sum, res;
`ifdef EXEC_LOGIC_FAST_EN
    logic               fast_q, fast_d;
    logic [63:0]        full;
`endif

    // Condition evaluation on {OF,SF,ZF}
    function automatic logic cond_eval(input logic [2:0] f, input logic [3:0] fn);
        logic lt;
        lt = f[1] ^ f[2];
        case (fn)
            4'd0:    cond_eval = 1'b1;
            4'd1:    cond_eval = lt | f[0];
            4'd2:    cond_eval = lt;
            4'd3:    cond_eval = f[0];
            4'd4:    cond_eval = ~f[0];
            4'd5:    cond_eval = ~lt;
            4'd6:    cond_eval = ~lt & ~f[0];
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // Operand and operation selection from the incoming instruction
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode)
            4'h2, 4'h6:       alu_a = valA;
            4'h3, 4'h4, 4'h5: alu_a = valC;
            4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            4'h9, 4'hB:       alu_a = 64'd8;
            default:          ;
        endcase
        case (icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = valB;
            default:                                  ;
        endcase
        op_sel     = (icode == 4'h6) ? alu_op_e'(ifun[1:0]) : OP_ADD;
        needs_calc = ((icode >= 4'h2 && icode <= 4'h6) || (icode >= 4'h8 && icode <= 4'hB))
                     && !(icode == 4'h6 && ifun > 4'd3);
    end

    // One slice of the ALU; operands shift down, result shifts in from the top
    always_comb begin
        a_sl      = a_q[SLICE_W-1:0];
        b_sl      = b_q[SLICE_W-1:0];
        {co, sum} = (SLICE_W+1)'(a_sl) + (SLICE_W+1)'(b_sl) + (SLICE_W+1)'(carry_q);
        case (op_q)
            OP_AND:  res = a_sl & b_sl;
            OP_XOR:  res = a_sl ^ b_sl;
            default: res = sum;
        endcase
        e_fin = (64'(res) << (64 - SLICE_W)) | (e_q >> SLICE_W);
        last  = (cnt_q == CNT_W'(NSL - 1));
`ifdef EXEC_LOGIC_FAST_EN
        case (op_q)
            OP_AND:  full = a_q & b_q;
            OP_XOR:  full = a_q ^ b_q;
            default: full = a_q + b_q;
        endcase
        if (fast_q) begin
            e_fin = full;
            last  = 1'b1;
        end
`endif
        case (op_q)
            OP_ADD:  of_c = (as_q == bs_q) & (e_fin[63] != as_q);
            OP_SUB:  of_c = (as_q != bs_q) & (e_fin[63] != bs_q);
            default: of_c = 1'b0;
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        e_d     = e_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        as_d    = as_q;
        bs_d    = bs_q;
        upd_d   = upd_q;
        cc_d    = cc_q;
        cnd_d   = cnd_q;
        err_d   = err_q;
`ifdef EXEC_LOGIC_FAST_EN
        fast_d  = fast_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op_sel;
                    a_d     = (op_sel == OP_SUB) ? ~alu_a : alu_a;
                    b_d     = alu_b;
                    e_d     = '0;
                    cnt_d   = '0;
                    carry_d = (op_sel == OP_SUB);
                    as_d    = alu_a[63];
                    bs_d    = alu_b[63];
                    upd_d   = (icode == 4'h6) && needs_calc;
                    cnd_d   = (icode == 4'h2 || icode == 4'h7) ? cond_eval(cc_q, ifun) : 1'b0;
                    err_d   = (icode == 4'h6) && (ifun > 4'd3);
`ifdef EXEC_LOGIC_FAST_EN
                    fast_d  = (op_sel == OP_AND) || (op_sel == OP_XOR) || (icode >= 4'h8);
`endif
                    state_d = needs_calc ? CALC : DONE;
                end
            end
            CALC: begin
                e_d     = e_fin;
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                carry_d = co;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    if (upd_q) cc_d = {of_c, e_fin[63], (e_fin == 64'd0)};
                end
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            e_q         <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            as_q        <= 1'b0;
            bs_q        <= 1'b0;
            upd_q       <= 1'b0;
            cc_q        <= 3'b001;
            cnd_q       <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef EXEC_LOGIC_FAST_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            as_q        <= as_d;
            bs_q        <= bs_d;
            upd_q       <= upd_d;
            cc_q        <= cc_d;
            cnd_q       <= cnd_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef EXEC_LOGIC_FAST_EN
            fast_q      <= fast_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign valE      = e_q;
    assign cnd       = cnd_q;
    assign cc        = cc_q;
    assign err       = err_q;
endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Randomized bench for exec_seq_ctrl against a whole-word arithmetic model of the execute stage.
module tb_exec_seq_ctrl;
    localparam int unsigned SLICE_W = 16;
    localparam int unsigned NSL     = 64 / SLICE_W;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, cnd, err;
    logic [3:0]  icode, ifun;
    logic [63:0] valA, valB, valC, valE;
    logic [2:0]  cc;

    int          n_tot, n_bad;
    logic [2:0]  cc_m;
    logic [63:0] last_e;
    logic        last_cnd;

    exec_seq_ctrl #(.SLICE_W(SLICE_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .out_valid(out_valid), .out_ready(out_ready), .valE(valE), .cnd(cnd),
        .cc(cc), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Whole-word reference for one instruction
    function automatic void model(input logic [3:0] ic, input logic [3:0] fn,
                                  input logic [63:0] va, input logic [63:0] vb,
                                  input logic [63:0] vc, input logic [2:0] ci,
                                  output logic [63:0] e, output logic [2:0] co,
                                  output logic c, output logic er, output logic calc);
        logic [63:0] a, b;
        logic zf, sf, of;
        a = 64'd0; b = 64'd0; e = 64'd0; co = ci; er = 1'b0; calc = 1'b0; of = 1'b0;
        if (ic == 2 || ic == 6) a = va;
        else if (ic >= 3 && ic <= 5) a = vc;
        else if (ic == 8 || ic == 10) a = -64'sd8;
        else if (ic == 9 || ic == 11) a = 64'd8;
        if ((ic >= 4 && ic <= 6) || (ic >= 8 && ic <= 11)) b = vb;
        if (ic == 6) begin
            if (fn > 3) er = 1'b1;
            else begin
                calc = 1'b1;
                case (fn)
                    0: begin e = b + a; of = (a[63] == b[63]) && (e[63] != a[63]); end
                    1: begin e = b - a; of = (a[63] != b[63]) && (e[63] != b[63]); end
                    2: e = b & a;
                    default: e = b ^ a;
                endcase
                co = {of, e[63], e == 64'd0};
            end
        end else if ((ic >= 2 && ic <= 5) || (ic >= 8 && ic <= 11)) begin
            calc = 1'b1;
            e = b + a;
        end
        zf = ci[0]; sf = ci[1]; of = ci[2];
        c = 1'b0;
        if (ic == 2 || ic == 7) begin
            case (fn)
                0: c = 1'b1;
                1: c = (sf != of) || zf;
                2: c = (sf != of);
                3: c = zf;
                4: c = !zf;
                5: c = (sf == of);
                6: c = (sf == of) && !zf;
                default: c = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one instruction at a negedge, then check result, hold behaviour and release
    task automatic run_op(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] va,
                          input logic [63:0] vb, input logic [63:0] vc, input int hold);
        logic [63:0] e_x;
        logic [2:0]  cc_x;
        logic        c_x, er_x, calc_x;
        int          cyc;
        model(ic, fn, va, vb, vc, cc_m, e_x, cc_x, c_x, er_x, calc_x);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        icode = ic; ifun = fn; valA = va; valB = vb; valC = vc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'($urandom_range(0, 1));
        icode = 4'($urandom); ifun = 4'($urandom);
        valA = {$urandom, $urandom}; valB = {$urandom, $urandom}; valC = {$urandom, $urandom};
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            in_valid = 1'($urandom_range(0, 1));
        end while (!out_valid && cyc < 100);
        if (!out_valid) begin
            n_tot++; n_bad++;
            $display("FAIL timeout: out_valid never rose for icode=%0h ifun=%0h", ic, fn);
            $display("test done: total=%0d bad=%0d", n_tot, n_bad);
            $fatal(1);
        end
`ifndef EXEC_LOGIC_FAST_EN
        check("latency", 64'(cyc), calc_x ? 64'(NSL + 1) : 64'd1);
`endif
        check("valE", valE, e_x);
        check("cnd", 64'(cnd), 64'(c_x));
        check("err", 64'(err), 64'(er_x));
        check("cc", 64'(cc), 64'(cc_x));
        last_e = valE; last_cnd = cnd;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_valE", valE, e_x);
            check("hold_cnd", 64'(cnd), 64'(c_x));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'($urandom_range(0, 1));
            icode = 4'($urandom);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_ready", 64'(in_ready), 64'd1);
        cc_m = cc_x;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] ic, fn;
        n_tot = 0; n_bad = 0;
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_valE", valE, 64'd0);
        check("rst_cnd", 64'(cnd), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cc", 64'(cc), 64'b001);
        @(negedge clk); rst_n = 1'b1; cc_m = 3'b001;
        @(negedge clk);

        run_op(4'h6, 4'h0, 64'd5, -64'sd5, 64'd0, 0);
        check("t1_valE", last_e, 64'd0);
        check("t1_cc", 64'(cc), 64'b001);
        run_op(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1);
        check("t2_valE", last_e, 64'h7FFF_FFFF_FFFF_FFFF);
        check("t2_cc", 64'(cc), 64'b100);
        run_op(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 0);
        run_op(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 0);
        check("t3_valE", last_e, 64'hF8);
        check("t3_cc", 64'(cc), 64'b001);
        check("t3_cnd", 64'(last_cnd), 64'd0);
        run_op(4'h6, 4'h1, 64'd3, 64'd1, 64'd0, 0);
        run_op(4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 0);
        check("t4_jle", 64'(last_cnd), 64'd1);
        run_op(4'h7, 4'h6, 64'd0, 64'd0, 64'h40, 0);
        check("t4_jg", 64'(last_cnd), 64'd0);
        run_op(4'h2, 4'h2, 64'h1234, 64'd0, 64'd0, 3);

        // Reset while an addq is mid-CALC
        icode = 4'h6; ifun = 4'h0; valA = 64'd9; valB = 64'd9; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); #1; rst_n = 1'b0; #1;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_valE", valE, 64'd0);
        check("t6_cc", 64'(cc), 64'b001);
        check("t6_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1; cc_m = 3'b001;
        run_op(4'h6, 4'h0, 64'd7, 64'd8, 64'd0, 0);
        check("t6_next", last_e, 64'd15);

        for (int i = 0; i < 150; i++) begin
            ic = 4'($urandom_range(0, 15));
            fn = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
            run_op(ic, fn, pick(), pick(), pick(), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
